// File: rtl/mux_scan_sequencer.sv
// Scan controller for a 16:1 enabled mux: steps sel 0..15, samples mux_out after SETTLE cycles, delivers a 16-bit word over valid/ready.
// Optional build macro SCAN_INVERT_EN stores ~mux_out instead of mux_out.
module mux_scan_sequencer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic [3:0]  sel,
    output logic        mux_dis,
    input  logic        mux_out,
    output logic [15:0] word,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        overrun
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_HOLD
    } state_t;

    localparam logic [3:0] LP_SETTLE = 4'(SETTLE);
    // With zero settle the SETTLE state is skipped on the entry edge.
    localparam state_t LP_FIRST = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_sel;
    logic [3:0]  r_cnt;
    logic [15:0] r_shadow;
    logic [15:0] r_word;
    logic        r_word_valid;
    logic        r_overrun;
    logic        w_bit;
    logic        w_handshake;
    logic        w_can_load;

`ifdef SCAN_INVERT_EN
    assign w_bit = ~mux_out;
`else
    assign w_bit = mux_out;
`endif

    assign w_handshake = r_word_valid && word_ready;
    assign w_can_load  = !r_word_valid || word_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = LP_FIRST;
                end
            end
            ST_SETTLE: begin
                if (r_cnt <= 4'd1) begin
                    w_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (r_sel != 4'd15) begin
                    w_next = LP_FIRST;
                end else if (w_can_load) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_handshake) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != ST_IDLE);
        mux_dis = (r_state == ST_IDLE) || (r_state == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel        <= '0;
            r_cnt        <= '0;
            r_shadow     <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            // A load later in this block overrides the clear on the same edge.
            if (w_handshake) begin
                r_word_valid <= 1'b0;
            end
            if (start && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sel <= '0;
                        r_cnt <= LP_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    r_cnt <= r_cnt - 4'd1;
                end
                ST_SAMPLE: begin
                    r_shadow[r_sel] <= w_bit;
                    if (r_sel != 4'd15) begin
                        r_sel <= r_sel + 4'd1;
                        r_cnt <= LP_SETTLE;
                    end else begin
                        r_sel <= '0;
                        if (w_can_load) begin
                            r_word       <= {w_bit, r_shadow[14:0]};
                            r_word_valid <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_handshake) begin
                        r_word       <= r_shadow;
                        r_word_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sel        = r_sel;
    assign word       = r_word;
    assign word_valid = r_word_valid;
    assign overrun    = r_overrun;

endmodule
